uart_rx_ext: RTL

- Next-generation UART receiver, replacing the fixed-format uart_rx in the serial transceiver path.
- Adds the following over uart_rx:
  - input synchroniser
  - 3-sample majority voting per bit
  - start-bit glitch rejection
  - configurable parity and stop bits
  - parity, framing and break reporting
- Drives a parallel word plus a one-cycle valid strobe to downstream logic; there is no backpressure.

---
 rtl/uart_rx_ext.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ext.sv
// UART receiver with input synchroniser, 3-sample majority voting, start-glitch
// rejection, configurable parity/stop bits and parity/framing/break reporting.
module uart_rx_ext #(
  parameter int unsigned CLOCK_RATE = 32'd1_000_000,
  parameter int unsigned BAUD_RATE  = 32'd115_200,
  parameter int unsigned DATA_WIDTH = 32'd8,
  parameter int unsigned PARITY     = 32'd0,
  parameter int unsigned STOP_BITS  = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data,
  output logic                  dv,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  brk
);

  localparam int unsigned CPB = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned MID = (CPB - 32'd1) / 32'd2;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned BW  = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 32'd1);
  localparam logic [CW-1:0] SMP_A     = CW'(MID - 32'd1);
  localparam logic [CW-1:0] SMP_B     = CW'(MID);
  localparam logic [CW-1:0] SMP_C     = CW'(MID + 32'd1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = BW'(32'd1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 32'd1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic maj3(input logic [2:0] s);
    maj3 = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Expected parity bit: even parity is the XOR of the data, odd its inverse.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 32'd2) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

  logic [1:0]            sync_r;
  logic                  rx_s;
  state_t                state_r, state_nx_s;
  logic [CW-1:0]         clk_cnt_r, clk_cnt_nx_s;
  logic [BW-1:0]         bit_cnt_r, bit_cnt_nx_s;
  logic                  stop_cnt_r, stop_cnt_nx_s;
  logic [2:0]            samp_r, samp_nx_s;
  logic [DATA_WIDTH-1:0] rx_byte_r, rx_byte_nx_s;
  logic                  par_err_r, par_err_nx_s;
  logic                  frm_err_r, frm_err_nx_s;
  logic                  all_low_r, all_low_nx_s;
  logic                  dv_r, dv_nx_s;
  logic [DATA_WIDTH-1:0] q_r, q_nx_s;
  logic                  parity_err_r, parity_err_nx_s;
  logic                  frame_err_r, frame_err_nx_s;
  logic                  brk_r, brk_nx_s;
  logic                  win_end_s;
  logic                  bit_s;
  logic                  frm_last_s;

  assign rx_s       = sync_r[1];
  assign win_end_s  = (clk_cnt_r == CNT_LAST);
  assign bit_s      = maj3(samp_r);
  assign frm_last_s = frm_err_r | ~bit_s;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], data};
    end
  end

  // Next-state, sampling and output-strobe logic.
  always_comb begin
    state_nx_s      = state_r;
    clk_cnt_nx_s    = clk_cnt_r;
    bit_cnt_nx_s    = bit_cnt_r;
    stop_cnt_nx_s   = stop_cnt_r;
    samp_nx_s       = samp_r;
    rx_byte_nx_s    = rx_byte_r;
    par_err_nx_s    = par_err_r;
    frm_err_nx_s    = frm_err_r;
    all_low_nx_s    = all_low_r;
    dv_nx_s         = 1'b0;
    q_nx_s          = q_r;
    parity_err_nx_s = 1'b0;
    frame_err_nx_s  = 1'b0;
    brk_nx_s        = 1'b0;

    if (win_end_s) begin
      clk_cnt_nx_s = CNT_ZERO;
    end else begin
      clk_cnt_nx_s = clk_cnt_r + CNT_ONE;
    end

    if (clk_cnt_r == SMP_A) begin
      samp_nx_s[0] = rx_s;
    end else if (clk_cnt_r == SMP_B) begin
      samp_nx_s[1] = rx_s;
    end else if (clk_cnt_r == SMP_C) begin
      samp_nx_s[2] = rx_s;
    end else begin
      samp_nx_s = samp_r;
    end

    case (state_r)
      ST_IDLE: begin
        // The cycle that first sees the line low is slot 0 of the start window.
        if (!rx_s) begin
          state_nx_s    = ST_START;
          clk_cnt_nx_s  = CNT_ONE;
          bit_cnt_nx_s  = BIT_ZERO;
          stop_cnt_nx_s = 1'b0;
          par_err_nx_s  = 1'b0;
          frm_err_nx_s  = 1'b0;
          all_low_nx_s  = 1'b1;
        end else begin
          clk_cnt_nx_s  = CNT_ZERO;
        end
      end
      ST_START: begin
        if (win_end_s) begin
          if (bit_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s   = ST_DATA;
            bit_cnt_nx_s = BIT_ZERO;
          end
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (win_end_s) begin
          rx_byte_nx_s = {bit_s, rx_byte_r[DATA_WIDTH-1:1]};
          all_low_nx_s = all_low_r & ~bit_s;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_nx_s  = BIT_ZERO;
            stop_cnt_nx_s = 1'b0;
            if (PARITY != 32'd0) begin
              state_nx_s = ST_PARITY;
            end else begin
              state_nx_s = ST_STOP;
            end
          end else begin
            bit_cnt_nx_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (win_end_s) begin
          par_err_nx_s  = (bit_s != parity_bit(rx_byte_r));
          all_low_nx_s  = all_low_r & ~bit_s;
          stop_cnt_nx_s = 1'b0;
          state_nx_s    = ST_STOP;
        end else begin
          state_nx_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (win_end_s) begin
          frm_err_nx_s = frm_last_s;
          all_low_nx_s = all_low_r & ~bit_s;
          if (stop_cnt_r == STOP_LAST) begin
            dv_nx_s         = 1'b1;
            q_nx_s          = rx_byte_r;
            parity_err_nx_s = par_err_r;
            frame_err_nx_s  = frm_last_s;
            brk_nx_s        = all_low_r & ~bit_s;
            if (frm_last_s) begin
              state_nx_s = ST_WAIT_IDLE;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            stop_cnt_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        // Hold off until the line returns high so a stuck-low line yields one frame.
        clk_cnt_nx_s = CNT_ZERO;
        if (rx_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        clk_cnt_nx_s = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      clk_cnt_r    <= CNT_ZERO;
      bit_cnt_r    <= BIT_ZERO;
      stop_cnt_r   <= 1'b0;
      samp_r       <= 3'b111;
      rx_byte_r    <= {DATA_WIDTH{1'b0}};
      par_err_r    <= 1'b0;
      frm_err_r    <= 1'b0;
      all_low_r    <= 1'b0;
      dv_r         <= 1'b0;
      q_r          <= {DATA_WIDTH{1'b0}};
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      brk_r        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      clk_cnt_r    <= clk_cnt_nx_s;
      bit_cnt_r    <= bit_cnt_nx_s;
      stop_cnt_r   <= stop_cnt_nx_s;
      samp_r       <= samp_nx_s;
      rx_byte_r    <= rx_byte_nx_s;
      par_err_r    <= par_err_nx_s;
      frm_err_r    <= frm_err_nx_s;
      all_low_r    <= all_low_nx_s;
      dv_r         <= dv_nx_s;
      q_r          <= q_nx_s;
      parity_err_r <= parity_err_nx_s;
      frame_err_r  <= frame_err_nx_s;
      brk_r        <= brk_nx_s;
    end
  end

  assign dv         = dv_r;
  assign q          = q_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign brk        = brk_r;

endmodule
